// File: rtl/eq_audio_pkg.sv
// Shared constants for the equalizer audio path and its I2S pins.
package eq_audio_pkg;

   localparam int unsigned AUDIO_W      = 24;
   localparam int unsigned I2S_SLOT_W   = 32;
   localparam int unsigned I2S_BCLK_DIV = 4;

   // Counter width for a modulo-n counter, never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// Master-mode I2S timing: divides clk down to BCLK and walks the frame bit counter.
module i2s_clk_gen
   import eq_audio_pkg::*;
#(
   parameter  int unsigned SLOT_W   = I2S_SLOT_W,
   parameter  int unsigned BCLK_DIV = I2S_BCLK_DIV,
   localparam int unsigned POS_W    = cnt_w(SLOT_W)
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             bclk_o,
   output logic             lrclk_o,
   output logic             fall_evt_c_o,
   output logic             frame_start_c_o,
   output logic             frame_pre_c_o,
   output logic [POS_W-1:0] pos_nxt_c_o,
   output logic             rslot_nxt_c_o
);

   localparam int unsigned DIV_W = cnt_w(BCLK_DIV);
   localparam int unsigned BIT_W = cnt_w(2 * SLOT_W);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(BCLK_DIV - 2);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);
   localparam logic [BIT_W-1:0] BIT_SLOT = BIT_W'(SLOT_W);

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic             bclk_q, bclk_d;
   logic             lrclk_q, lrclk_d;
   logic             fall_evt;
   logic [POS_W-1:0] pos_nxt;

   assign fall_evt = (div_cnt_q == DIV_LAST);

   // Divider wrap and bit advance; bclk/lrclk are decoded from the next counts.
   always_comb begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
      bit_cnt_d = bit_cnt_q;
      if (fall_evt) begin
         div_cnt_d = '0;
         bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BIT_W'(1);
      end
      bclk_d  = (div_cnt_d >= DIV_HALF);
      lrclk_d = (bit_cnt_d >= BIT_SLOT);
   end

   // Slot position of the bit about to be driven, so sdata can register alongside lrclk.
   always_comb begin
      pos_nxt = POS_W'(bit_cnt_d);
      if (lrclk_d) begin
         pos_nxt = POS_W'(bit_cnt_d - BIT_SLOT);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q <= '0;
         bit_cnt_q <= BIT_LAST;
         bclk_q    <= 1'b0;
         lrclk_q   <= 1'b0;
      end else begin
         div_cnt_q <= div_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         bclk_q    <= bclk_d;
         lrclk_q   <= lrclk_d;
      end
   end

   assign bclk_o          = bclk_q;
   assign lrclk_o         = lrclk_q;
   assign fall_evt_c_o    = fall_evt;
   assign frame_start_c_o = fall_evt && (bit_cnt_q == BIT_LAST);
   // One cycle ahead of frame start, so the underrun flag can be registered.
   assign frame_pre_c_o   = (div_cnt_q == DIV_PRE) && (bit_cnt_q == BIT_LAST);
   assign pos_nxt_c_o     = pos_nxt;
   assign rslot_nxt_c_o   = lrclk_d;

endmodule

// File: rtl/i2s_tx.sv
// I2S master transmitter: one-deep stereo holding buffer feeding a Philips-format serializer.
module i2s_tx
   import eq_audio_pkg::*;
#(
   parameter int unsigned DATA_W   = AUDIO_W,
   parameter int unsigned SLOT_W   = I2S_SLOT_W,
   parameter int unsigned BCLK_DIV = I2S_BCLK_DIV
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] sample_l,
   input  logic [DATA_W-1:0] sample_r,
   input  logic              sample_valid,
   output logic              sample_ready,
   output logic              i2s_bclk,
   output logic              i2s_lrclk,
   output logic              i2s_sdata,
   output logic              underrun
);

   localparam int unsigned      POS_W    = cnt_w(SLOT_W);
   localparam logic [POS_W-1:0] POS_DATA = POS_W'(DATA_W);

   logic              buf_empty_q, buf_empty_d;
   logic [DATA_W-1:0] buf_l_q, buf_l_d;
   logic [DATA_W-1:0] buf_r_q, buf_r_d;
   logic [DATA_W-1:0] shadow_l_q, shadow_l_d;
   logic [DATA_W-1:0] shadow_r_q, shadow_r_d;
   logic              sdata_q, sdata_d;
   logic              underrun_q, underrun_d;

   logic              fall_evt;
   logic              frame_start;
   logic              frame_pre;
   logic [POS_W-1:0]  pos_nxt;
   logic              rslot_nxt;
   logic              accept;
   logic [DATA_W-1:0] shadow_sel;
   logic [POS_W-1:0]  bit_idx;
   logic              bit_in_word;
   logic              data_bit;

   i2s_clk_gen #(
      .SLOT_W   (SLOT_W),
      .BCLK_DIV (BCLK_DIV)
   ) u_clk_gen (
      .clk             (clk),
      .rst_n           (rst_n),
      .bclk_o          (i2s_bclk),
      .lrclk_o         (i2s_lrclk),
      .fall_evt_c_o    (fall_evt),
      .frame_start_c_o (frame_start),
      .frame_pre_c_o   (frame_pre),
      .pos_nxt_c_o     (pos_nxt),
      .rslot_nxt_c_o   (rslot_nxt)
   );

   assign accept = sample_valid && buf_empty_q;

   // Position 1 carries the MSB; position 0 is the I2S delay bit and tail positions are padding.
   assign shadow_sel  = rslot_nxt ? shadow_r_q : shadow_l_q;
   assign bit_idx     = POS_DATA - pos_nxt;
   assign bit_in_word = (pos_nxt != '0) && (pos_nxt <= POS_DATA);

   always_comb begin
      data_bit = 1'b0;
      for (int unsigned i = 0; i < DATA_W; i++) begin
         if (bit_idx == POS_W'(i)) begin
            data_bit = shadow_sel[i];
         end
      end
   end

   // Buffer handshake, frame-start shadow load and serial bit selection.
   always_comb begin
      buf_empty_d = buf_empty_q;
      buf_l_d     = buf_l_q;
      buf_r_d     = buf_r_q;
      shadow_l_d  = shadow_l_q;
      shadow_r_d  = shadow_r_q;
      sdata_d     = sdata_q;
      underrun_d  = 1'b0;

      if (frame_start) begin
         if (buf_empty_q) begin
            shadow_l_d = '0;
            shadow_r_d = '0;
         end else begin
            shadow_l_d  = buf_l_q;
            shadow_r_d  = buf_r_q;
            buf_empty_d = 1'b1;
         end
      end

      // Only possible while empty, so never collides with the load above.
      if (accept) begin
         buf_l_d     = sample_l;
         buf_r_d     = sample_r;
         buf_empty_d = 1'b0;
      end

      if (fall_evt) begin
         sdata_d = bit_in_word && data_bit;
      end

      underrun_d = frame_pre && buf_empty_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_empty_q <= 1'b1;
         buf_l_q     <= '0;
         buf_r_q     <= '0;
         shadow_l_q  <= '0;
         shadow_r_q  <= '0;
         sdata_q     <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         buf_empty_q <= buf_empty_d;
         buf_l_q     <= buf_l_d;
         buf_r_q     <= buf_r_d;
         shadow_l_q  <= shadow_l_d;
         shadow_r_q  <= shadow_r_d;
         sdata_q     <= sdata_d;
         underrun_q  <= underrun_d;
      end
   end

   assign sample_ready = buf_empty_q;
   assign i2s_sdata    = sdata_q;
   assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx: frame-level model feeds an expected-frame queue, a serial monitor consumes it.
`timescale 1ns/1ps
module tb_i2s_tx;

   logic        clk;
   logic        rst_n;
   logic [23:0] sample_l;
   logic [23:0] sample_r;
   logic        sample_valid;
   logic        sample_ready;
   logic        i2s_bclk;
   logic        i2s_lrclk;
   logic        i2s_sdata;
   logic        underrun;

   i2s_tx #(
      .DATA_W   (24),
      .SLOT_W   (32),
      .BCLK_DIV (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_l     (sample_l),
      .sample_r     (sample_r),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .i2s_bclk     (i2s_bclk),
      .i2s_lrclk    (i2s_lrclk),
      .i2s_sdata    (i2s_sdata),
      .underrun     (underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          frames_seen = 0;
   logic [63:0] exp_q[$];
   logic [23:0] mbuf_l, mbuf_r;
   bit          mbuf_full = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One frame as seen at successive bclk rising edges, first bit = lrclk transition bit.
   function automatic logic [63:0] frame_bits(input logic [23:0] l, input logic [23:0] r);
      return {1'b0, l, 7'b0, 1'b0, r, 7'b0};
   endfunction

   // Reference model: frames begin every 256 clk from cycle 3; one-deep buffer.
   initial begin : model
      bit fs;
      bit was_empty;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            cyc       = 0;
            mbuf_full = 1'b0;
            exp_q.delete();
         end else begin
            fs        = ((cyc % 256) == 3);
            was_empty = !mbuf_full;
            chk("ready", sample_ready, was_empty);
            chk("underrun", underrun, fs && was_empty);
            chk("bclk", i2s_bclk, (cyc % 4) >= 2);
            if (fs) begin
               exp_q.push_back(was_empty ? 64'h0 : frame_bits(mbuf_l, mbuf_r));
               mbuf_full = 1'b0;
            end
            if (sample_valid && was_empty) begin
               mbuf_l    = sample_l;
               mbuf_r    = sample_r;
               mbuf_full = 1'b1;
            end
            cyc++;
         end
      end
   end

   // Serial monitor: collects 64 bits per frame at bclk rising edges and scores them.
   initial begin : monitor
      logic [63:0] rx, rx_lr, exp;
      int          nbits;
      bit          prev, skip;
      rx = '0; rx_lr = '0; nbits = 0; prev = 1'b0; skip = 1'b1;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            nbits = 0;
            prev  = 1'b0;
            skip  = 1'b1;
         end else begin
            if (i2s_bclk && !prev) begin
               if (skip) begin
                  skip = 1'b0;
               end else begin
                  rx    = {rx[62:0], i2s_sdata};
                  rx_lr = {rx_lr[62:0], i2s_lrclk};
                  nbits++;
                  if (nbits == 64) begin
                     nbits = 0;
                     frames_seen++;
                     chk("frame_expected", exp_q.size() != 0, 1);
                     if (exp_q.size() != 0) begin
                        exp = exp_q.pop_front();
                        chk("frame_sdata", rx, exp);
                        chk("frame_lrclk", rx_lr, 64'h00000000_FFFFFFFF);
                     end
                  end
               end
            end
            prev = i2s_bclk;
         end
      end
   end

   task automatic apply_reset();
      sample_valid = 1'b0;
      rst_n        = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic wait_cyc(input int target);
      int guard = 0;
      while (cyc < target && guard < 5000) begin
         @(posedge clk);
         #1;
         guard++;
      end
      chk("wait_cyc_bound", guard >= 5000, 0);
   endtask

   task automatic send(input logic [23:0] l, input logic [23:0] r, output int acc_cyc);
      int guard = 0;
      sample_valid = 1'b1;
      sample_l     = l;
      sample_r     = r;
      @(negedge clk);
      while (!sample_ready && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      chk("send_bound", guard >= 2000, 0);
      @(posedge clk);
      #1;
      acc_cyc = cyc - 1;
   endtask

   initial begin : driver
      int          acc[6];
      int          a;
      logic [23:0] base_l, base_r, pa_l, pa_r;

      rst_n        = 1'b0;
      sample_valid = 1'b0;
      sample_l     = '0;
      sample_r     = '0;

      // Reset state
      #12;
      chk("rst_bclk", i2s_bclk, 0);
      chk("rst_lrclk", i2s_lrclk, 0);
      chk("rst_sdata", i2s_sdata, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_ready", sample_ready, 1);

      // Idle: silence and an underrun every frame
      apply_reset();
      wait_cyc(780);

      // Single frame loaded before the first frame start
      apply_reset();
      send(24'h800001, 24'h7FFFFF, a);
      sample_valid = 1'b0;
      chk("single_accept_cycle", a, 0);
      wait_cyc(520);

      // Back-pressure with incrementing pairs
      apply_reset();
      base_l = 24'($urandom);
      base_r = 24'($urandom);
      for (int k = 0; k < 6; k++) begin
         send(base_l + 24'(k), base_r + 24'(k), acc[k]);
         if (k >= 2) chk("bp_accept_interval", acc[k] - acc[k-1], 256);
      end
      sample_valid = 1'b0;
      chk("bp_first_accept", acc[0], 0);
      chk("bp_refill_accept", acc[1], 4);
      wait_cyc(1600);

      // Valid first raised on the second frame-start cycle
      apply_reset();
      wait_cyc(259);
      send(24'($urandom), 24'($urandom), a);
      sample_valid = 1'b0;
      chk("coinc_accept_cycle", a, 259);
      wait_cyc(800);

      // Reset in the middle of the left slot with a pair still buffered
      apply_reset();
      pa_l = 24'($urandom) | 24'h004000;
      pa_r = 24'($urandom);
      send(pa_l, pa_r, a);
      send(24'($urandom), 24'($urandom), a);
      sample_valid = 1'b0;
      wait_cyc(46);
      chk("mid_pre_bclk", i2s_bclk, 1);
      chk("mid_pre_sdata", i2s_sdata, 1);
      chk("mid_pre_ready", sample_ready, 0);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_bclk", i2s_bclk, 0);
      chk("mid_rst_lrclk", i2s_lrclk, 0);
      chk("mid_rst_sdata", i2s_sdata, 0);
      chk("mid_rst_underrun", underrun, 0);
      chk("mid_rst_ready", sample_ready, 1);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      wait_cyc(540);

      // Randomized traffic with freely changing data
      apply_reset();
      for (int i = 0; i < 2000; i++) begin
         sample_valid = ($urandom_range(0, 99) < 3);
         sample_l     = 24'($urandom);
         sample_r     = 24'($urandom);
         @(posedge clk);
         #1;
      end
      sample_valid = 1'b0;
      wait_cyc(2320);

      chk("frames_scored", frames_seen >= 20, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
